// File: rtl/mdu_iter_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Holds the funct3 op encodings, FSM states and operand-sign helpers.
package mdu_iter_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 6;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } mdu_state_e;

   function automatic logic rs1_signed(input mdu_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic rs2_signed(input mdu_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // Two's-complement magnitude; the most negative value maps onto itself,
   // which is the correct unsigned magnitude 2^(XLEN-1).
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (XLEN'(0) - v) : v;
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the core pipeline and the multiply/divide unit.
interface mdu_iter_if;
   import mdu_iter_pkg::*;

   logic            start;
   logic            kill;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, kill, op, rs1_data, rs2_data,
      input  busy, done, result
   );

   modport slave (
      input  start, kill, op, rs1_data, rs2_data,
      output busy, done, result
   );
endinterface

// File: rtl/mdu_iter_shift_core.sv
// 64-bit shift accumulator with one add (multiply) or trial-subtract (divide) step per cycle.
// Multiply: {hi, lo} = {partial product, multiplier}; divide: {remainder, dividend/quotient}.
module mdu_iter_shift_core
   import mdu_iter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [2*XLEN-1:0] load_val,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] acc
);

   logic [2*XLEN-1:0] acc_reg;
   logic [2*XLEN-1:0] acc_next;
   logic [2*XLEN-1:0] mul_next;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     rem_shift;
   logic [XLEN-1:0]   rem_diff;
   logic              rem_ge;

   always_comb begin
      // Shift-add: conditionally add the multiplicand, then shift the carry in.
      add_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]}
               + (acc_reg[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
      mul_next = {add_sum, acc_reg[XLEN-1:1]};

      // Restoring divide: remainder is below the divisor, so the difference fits XLEN bits.
      rem_shift = acc_reg[2*XLEN-1:XLEN-1];
      rem_ge    = (rem_shift >= {1'b0, operand});
      rem_diff  = rem_shift[XLEN-1:0] - operand;
      div_next  = {(rem_ge ? rem_diff : rem_shift[XLEN-1:0]), acc_reg[XLEN-2:0], rem_ge};

      acc_next = acc_reg;
      if (load) begin
         acc_next = load_val;
      end else if (step) begin
         acc_next = is_div ? div_next : mul_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg <= '0;
      end else begin
         acc_reg <= acc_next;
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32 shift iterations, then sign fix-up and a one-cycle done.
// Divide-by-zero and signed overflow skip the iterations and finish on the next edge.
module mdu_iter
   import mdu_iter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   mdu_iter_if.slave  bus
);

   mdu_state_e        state_reg;
   mdu_op_e           op_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              neg_q_reg;
   logic              neg_r_reg;
   logic              special_reg;
   logic [XLEN-1:0]   opnd_reg;
   logic [XLEN-1:0]   special_val_reg;
   logic [XLEN-1:0]   result_reg;

   mdu_op_e           op_in;
   logic              sign_a;
   logic              sign_b;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic              div_zero;
   logic              div_ovf;
   logic              special_in;
   logic [XLEN-1:0]   special_val_in;
   logic [2*XLEN-1:0] load_val;
   logic              accept;
   logic              step;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   final_val;

   always_comb begin
      op_in    = mdu_op_e'(bus.op);
      sign_a   = rs1_signed(op_in) & bus.rs1_data[XLEN-1];
      sign_b   = rs2_signed(op_in) & bus.rs2_data[XLEN-1];
      mag_a    = magnitude(bus.rs1_data, sign_a);
      mag_b    = magnitude(bus.rs2_data, sign_b);
      div_zero = (bus.rs2_data == '0);
      div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM))
               && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
               && (bus.rs2_data == {XLEN{1'b1}});
      special_in = op_in[2] & (div_zero | div_ovf);

      // op[1] separates remainder ops from quotient ops.
      special_val_in = '0;
      if (div_zero) begin
         special_val_in = op_in[1] ? bus.rs1_data : {XLEN{1'b1}};
      end else if (div_ovf) begin
         special_val_in = op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end

      load_val = op_in[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      accept   = (state_reg == ST_IDLE) && bus.start && !bus.kill;
      step     = (state_reg == ST_CALC) && !bus.kill && (cnt_reg != LAST_CNT);
   end

   mdu_iter_shift_core u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .step     (step),
      .is_div   (op_reg[2]),
      .load_val (load_val),
      .operand  (opnd_reg),
      .acc      (acc)
   );

   always_comb begin
      prod_fix = neg_q_reg ? ((2*XLEN)'(0) - acc) : acc;
      quot_fix = neg_q_reg ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0];
      rem_fix  = neg_r_reg ? (XLEN'(0) - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];

      final_val = '0;
      if (special_reg) begin
         final_val = special_val_reg;
      end else begin
         case (op_reg)
            OP_MUL:                     final_val = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            final_val = quot_fix;
            default:                    final_val = rem_fix;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         op_reg          <= OP_MUL;
         cnt_reg         <= '0;
         neg_q_reg       <= 1'b0;
         neg_r_reg       <= 1'b0;
         special_reg     <= 1'b0;
         opnd_reg        <= '0;
         special_val_reg <= '0;
         result_reg      <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  op_reg          <= op_in;
                  neg_q_reg       <= sign_a ^ sign_b;
                  neg_r_reg       <= sign_a;
                  special_reg     <= special_in;
                  special_val_reg <= special_val_in;
                  opnd_reg        <= op_in[2] ? mag_b : mag_a;
                  // Special cases jump the counter to its end and take one finishing cycle.
                  cnt_reg         <= special_in ? LAST_CNT : '0;
                  state_reg       <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (bus.kill) begin
                  state_reg <= ST_IDLE;
               end else if (cnt_reg == LAST_CNT) begin
                  result_reg <= final_val;
                  state_reg  <= ST_FIN;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            ST_FIN: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = (state_reg != ST_IDLE);
   assign bus.done   = (state_reg == ST_FIN);
   assign bus.result = result_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic results, latency, special cases, kill, reset and start-while-busy.
module tb_mdu_iter;
   import mdu_iter_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   passed;
   logic [31:0] last_result;
   int   c;
   logic seen_done;

   mdu_iter_if bus ();

   mdu_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string tag);
      int n;
      @(negedge clk);
      bus.op       = op;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
      n = 0;
      while (!bus.done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'(exp_lat));
      check({tag, " result"}, bus.result, exp);
      check({tag, " busy_in_done"}, {31'b0, bus.busy}, 32'd1);
      @(negedge clk);
      check({tag, " done_drop"}, {31'b0, bus.done}, 32'd0);
      $display("op=%0d a=%h b=%h result=%h latency=%0d (%s)", op, a, b, bus.result, n, tag);
      last_result = exp;
   endtask

   initial begin
      total = 0;
      passed = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.kill = 1'b0;
      bus.op = 3'd0;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset busy", {31'b0, bus.busy}, 32'd0);
      check("reset done", {31'b0, bus.done}, 32'd0);
      check("reset result", bus.result, 32'd0);

      run_op(OP_MUL,    32'd7,          32'd6,          32'd42,         33, "MUL 7*6");
      run_op(OP_MULH,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33, "MULH");
      run_op(OP_MULHU,  32'hFFFF_FFFF,  32'd2,          32'd1,          33, "MULHU");
      run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33, "MULHSU");
      run_op(OP_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  33, "MUL -3*5");
      run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, "DIV -7/2");
      run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, "REM -7%2");
      run_op(OP_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, "DIV 7/-2");
      run_op(OP_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          33, "REM 7%-2");
      run_op(OP_DIVU,   32'd100,        32'd7,          32'd14,         33, "DIVU 100/7");
      run_op(OP_REMU,   32'd100,        32'd7,          32'd2,          33, "REMU 100%7");
      run_op(OP_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "DIV 5/0");
      run_op(OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "DIVU 5/0");
      run_op(OP_REM,    32'd5,          32'd0,          32'd5,          1,  "REM 5%0");

      // kill at CALC cycle 10: no done, result untouched
      @(negedge clk);
      bus.op = OP_MUL; bus.rs1_data = 32'd9; bus.rs2_data = 32'd9; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      check("kill busy", {31'b0, bus.busy}, 32'd0);
      check("kill result", bus.result, last_result);
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) seen_done = 1'b1;
      end
      check("kill no_done", {31'b0, seen_done}, 32'd0);
      $display("kill mid-CALC: busy=%0b result=%h", bus.busy, bus.result);

      run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "DIV ovf");
      run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "REM ovf");

      // start while busy is ignored
      @(negedge clk);
      bus.op = OP_MUL; bus.rs1_data = 32'd7; bus.rs2_data = 32'd6; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      c = 0;
      repeat (4) begin
         @(negedge clk);
         c++;
      end
      bus.op = OP_DIV; bus.rs1_data = 32'd100; bus.rs2_data = 32'd5; bus.start = 1'b1;
      @(negedge clk);
      c++;
      bus.start = 1'b0;
      while (!bus.done && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("busy_start latency", 32'(c), 32'd33);
      check("busy_start result", bus.result, 32'd42);
      repeat (3) @(negedge clk);
      check("busy_start idle", {31'b0, bus.busy}, 32'd0);
      $display("start while busy: result=%h latency=%0d", bus.result, c);

      // kill overrides start in IDLE
      @(negedge clk);
      bus.op = OP_MUL; bus.rs1_data = 32'd3; bus.rs2_data = 32'd3;
      bus.start = 1'b1; bus.kill = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.kill = 1'b0;
      check("idle_kill busy", {31'b0, bus.busy}, 32'd0);
      $display("kill in IDLE: busy=%0b", bus.busy);

      // async reset mid-CALC
      @(negedge clk);
      bus.op = OP_MUL; bus.rs1_data = 32'd5; bus.rs2_data = 32'd5; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      check("rst pre busy", {31'b0, bus.busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst busy", {31'b0, bus.busy}, 32'd0);
      check("rst done", {31'b0, bus.done}, 32'd0);
      check("rst result", bus.result, 32'd0);
      $display("async rst mid-CALC: busy=%0b result=%h", bus.busy, bus.result);
      @(negedge clk);
      rst = 1'b0;

      run_op(OP_MULHU,  32'h8000_0000,  32'd4,          32'd2,          33, "MULHU after rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
